// File: rtl/core_run_monitor.sv
// +----------------------------------------------------------------------------+
// | core_run_monitor: tracks a core run from start to halt/timeout, counting    |
// | cycles and writebacks into a rotating-XOR signature. Optional PC history    |
// | buffer enabled by RUN_MON_PC_HISTORY_EN.                                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_run_monitor #(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 32,
    parameter int              MAX_CYCLES   = 100000,
    parameter int              STALL_CYCLES = 4,
    parameter logic [XLEN-1:0] EXPECTED_SIG = 32'h0,
    parameter int              HIST_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [XLEN-1:0]               pc_in,
    input  logic [XLEN-1:0]               result_in,
    input  logic                          wb_valid,
    output logic [1:0]                    state,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              instr_count,
    output logic [XLEN-1:0]               signature
`ifdef RUN_MON_PC_HISTORY_EN
    ,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [XLEN-1:0]               hist_pc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int               STALL_W    = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cycle_q,   cycle_d;
    logic [CNT_W-1:0]   instr_q,   instr_d;
    logic [XLEN-1:0]    sig_q,     sig_d;
    logic [STALL_W-1:0] stall_q,   stall_d;
    logic [XLEN-1:0]    prev_pc_q, prev_pc_d;
    logic               w_pc_same;
    logic               w_start_acc;

    assign w_pc_same   = (pc_in == prev_pc_q);
    assign w_start_acc = start && (state_q != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cycle_q   <= '0;
            instr_q   <= '0;
            sig_q     <= '0;
            stall_q   <= '0;
            prev_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            sig_q     <= sig_d;
            stall_q   <= stall_d;
            prev_pc_q <= prev_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        sig_d     = sig_q;
        stall_d   = stall_q;
        prev_pc_d = prev_pc_q;
        case (state_q)
            ST_RUN: begin
                cycle_d = cycle_q + 1'b1;
                if (wb_valid) begin
                    instr_d = instr_q + 1'b1;
                    sig_d   = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ result_in;
                end
                if (w_pc_same) begin
                    if (stall_q != STALL_LAST) begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    stall_d = '0;
                end
                prev_pc_d = pc_in;
                // Halt has priority over a timeout landing on the same edge.
                if (w_pc_same && (stall_q == STALL_LAST)) begin
                    state_d = ST_HALTED;
                end else if (cycle_q == CYC_LAST) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cycle_d   = '0;
                    instr_d   = '0;
                    sig_d     = '0;
                    stall_d   = '0;
                    prev_pc_d = pc_in;
                end
            end
        endcase
    end

    assign state       = state_q;
    assign done        = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
    assign pass        = (state_q == ST_HALTED) && (sig_q == EXPECTED_SIG);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign signature   = sig_q;

`ifdef RUN_MON_PC_HISTORY_EN
    localparam int HIST_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic [XLEN-1:0]   hist_q [HIST_DEPTH];
    logic [HIST_W-1:0] wr_ptr_q;
    logic [HIST_W-1:0] w_rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (w_start_acc) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if ((state_q == ST_RUN) && !w_pc_same) begin
            hist_q[wr_ptr_q] <= pc_in;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
    end

    // Index 0 is the most recent write, one behind the write pointer.
    assign w_rd_idx = wr_ptr_q - HIST_W'(1) - hist_idx;
    assign hist_pc  = hist_q[w_rd_idx];
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_run_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_core_run_monitor: directed self-checking bench for core_run_monitor.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_core_run_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc_in;
    logic [31:0] result_in;
    logic        wb_valid;
    logic [1:0]  state;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] signature;
`ifdef RUN_MON_PC_HISTORY_EN
    logic [2:0]  hist_idx;
    logic [31:0] hist_pc;
`endif

    int vec_cnt;
    int miss_cnt;

    core_run_monitor #(
        .XLEN         (32),
        .CNT_W        (32),
        .MAX_CYCLES   (20),
        .STALL_CYCLES (4),
        .EXPECTED_SIG (32'h0000_0040),
        .HIST_DEPTH   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc_in       (pc_in),
        .result_in   (result_in),
        .wb_valid    (wb_valid),
        .state       (state),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .signature   (signature)
`ifdef RUN_MON_PC_HISTORY_EN
        ,
        .hist_idx    (hist_idx),
        .hist_pc     (hist_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [31:0] pc, input logic wbv, input logic [31:0] res);
        pc_in     = pc;
        wb_valid  = wbv;
        result_in = res;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] pc);
        start = 1'b1;
        step(pc, 1'b0, 32'h0);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++; if (state !== 2'd0) begin miss_cnt++; $display("FAIL reset_state: got %0d want 0", state); end
        vec_cnt++; if ({done, pass, timeout} !== 3'b000) begin miss_cnt++; $display("FAIL reset_flags: got %b want 000", {done, pass, timeout}); end
        vec_cnt++; if ({cycle_count, instr_count, signature} !== 96'h0) begin miss_cnt++; $display("FAIL reset_counts: got %h/%h/%h want 0", cycle_count, instr_count, signature); end
        rst = 1'b0;
        step(32'h0, 1'b0, 32'h0);
        vec_cnt++; if (state !== 2'd0) begin miss_cnt++; $display("FAIL idle_hold: got %0d want 0", state); end
    endtask

    task automatic test_normal_halt;
        do_start(32'h0);
        vec_cnt++; if (state !== 2'd1) begin miss_cnt++; $display("FAIL start_run: got %0d want 1", state); end
        for (int k = 1; k <= 10; k++) step(32'(4 * k), 1'b1, 32'(k));
        for (int k = 11; k <= 13; k++) step(32'h28, 1'b0, 32'h0);
        vec_cnt++; if (state !== 2'd1) begin miss_cnt++; $display("FAIL halt_not_early: got %0d want 1", state); end
        step(32'h28, 1'b0, 32'h0);
        vec_cnt++; if (state !== 2'd2) begin miss_cnt++; $display("FAIL halt_state: got %0d want 2", state); end
        vec_cnt++; if (cycle_count !== 32'd14) begin miss_cnt++; $display("FAIL halt_cycles: got %0d want 14", cycle_count); end
        vec_cnt++; if (instr_count !== 32'd10) begin miss_cnt++; $display("FAIL halt_instrs: got %0d want 10", instr_count); end
        vec_cnt++; if (signature !== 32'h0000_0040) begin miss_cnt++; $display("FAIL halt_sig: got %h want 00000040", signature); end
        vec_cnt++; if ({done, pass, timeout} !== 3'b110) begin miss_cnt++; $display("FAIL halt_flags: got %b want 110", {done, pass, timeout}); end
        step(32'h2C, 1'b1, 32'h5);
        vec_cnt++; if ({state, cycle_count, instr_count, signature} !== {2'd2, 32'd14, 32'd10, 32'h40}) begin
            miss_cnt++; $display("FAIL halt_frozen: got %0d/%0d/%0d/%h want 2/14/10/40", state, cycle_count, instr_count, signature);
        end
    endtask

    task automatic test_restart;
        do_start(32'h100);
        vec_cnt++; if ({state, cycle_count, instr_count, signature} !== {2'd1, 96'h0}) begin
            miss_cnt++; $display("FAIL restart_clear: got %0d/%0d/%0d/%h want 1/0/0/0", state, cycle_count, instr_count, signature);
        end
        vec_cnt++; if ({done, pass} !== 2'b00) begin miss_cnt++; $display("FAIL restart_flags: got %b want 00", {done, pass}); end
        for (int i = 1; i <= 3; i++) step(32'h100 + 32'(4 * i), 1'b0, 32'h0);
        start = 1'b1;
        step(32'h110, 1'b0, 32'h0);
        start = 1'b0;
        vec_cnt++; if ({state, cycle_count} !== {2'd1, 32'd4}) begin
            miss_cnt++; $display("FAIL start_in_run: got %0d/%0d want 1/4", state, cycle_count);
        end
    endtask

    task automatic test_timeout;
        for (int i = 1; i <= 15; i++) step(32'h110 + 32'(4 * i), 1'b0, 32'h0);
        vec_cnt++; if ({state, cycle_count} !== {2'd1, 32'd19}) begin
            miss_cnt++; $display("FAIL to_not_early: got %0d/%0d want 1/19", state, cycle_count);
        end
        step(32'h150, 1'b0, 32'h0);
        vec_cnt++; if ({state, cycle_count} !== {2'd3, 32'd20}) begin
            miss_cnt++; $display("FAIL to_state: got %0d/%0d want 3/20", state, cycle_count);
        end
        vec_cnt++; if ({done, pass, timeout} !== 3'b101) begin miss_cnt++; $display("FAIL to_flags: got %b want 101", {done, pass, timeout}); end
        step(32'h154, 1'b1, 32'h7);
        vec_cnt++; if ({cycle_count, instr_count} !== {32'd20, 32'd0}) begin
            miss_cnt++; $display("FAIL to_frozen: got %0d/%0d want 20/0", cycle_count, instr_count);
        end
    endtask

    task automatic test_simultaneous;
        do_start(32'h0);
        vec_cnt++; if ({state, cycle_count} !== {2'd1, 32'd0}) begin
            miss_cnt++; $display("FAIL sim_start: got %0d/%0d want 1/0", state, cycle_count);
        end
        for (int k = 1; k <= 16; k++) step(32'(4 * k), 1'b0, 32'h0);
        for (int k = 17; k <= 19; k++) step(32'h40, 1'b0, 32'h0);
        vec_cnt++; if (state !== 2'd1) begin miss_cnt++; $display("FAIL sim_not_early: got %0d want 1", state); end
        step(32'h40, 1'b0, 32'h0);
        vec_cnt++; if ({state, cycle_count} !== {2'd2, 32'd20}) begin
            miss_cnt++; $display("FAIL sim_state: got %0d/%0d want 2/20", state, cycle_count);
        end
        vec_cnt++; if ({done, pass, timeout} !== 3'b100) begin miss_cnt++; $display("FAIL sim_flags: got %b want 100", {done, pass, timeout}); end
    endtask

    task automatic test_reset_midrun;
        do_start(32'h0);
        for (int k = 1; k <= 15; k++) step(32'(4 * k), 1'b1, 32'(k));
        vec_cnt++; if ({state, cycle_count, instr_count} !== {2'd1, 32'd15, 32'd15}) begin
            miss_cnt++; $display("FAIL mid_pre: got %0d/%0d/%0d want 1/15/15", state, cycle_count, instr_count);
        end
        #3;
        rst = 1'b1;
        #1;
        vec_cnt++; if ({state, cycle_count, instr_count, signature} !== {2'd0, 96'h0}) begin
            miss_cnt++; $display("FAIL mid_async: got %0d/%0d/%0d/%h want 0/0/0/0", state, cycle_count, instr_count, signature);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_start(32'h0);
        vec_cnt++; if ({state, cycle_count} !== {2'd1, 32'd0}) begin
            miss_cnt++; $display("FAIL mid_restart: got %0d/%0d want 1/0", state, cycle_count);
        end
    endtask

`ifdef RUN_MON_PC_HISTORY_EN
    task automatic test_history;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        do_start(32'hFFFF_FFF0);
        for (int i = 0; i < 12; i++) step(32'(4 * i), 1'b0, 32'h0);
        hist_idx = 3'd0;
        #1;
        vec_cnt++; if (hist_pc !== 32'h2C) begin miss_cnt++; $display("FAIL hist_newest: got %h want 0000002c", hist_pc); end
        hist_idx = 3'd7;
        #1;
        vec_cnt++; if (hist_pc !== 32'h10) begin miss_cnt++; $display("FAIL hist_oldest: got %h want 00000010", hist_pc); end
    endtask
`endif

    initial begin
        vec_cnt   = 0;
        miss_cnt  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pc_in     = '0;
        result_in = '0;
        wb_valid  = 1'b0;
`ifdef RUN_MON_PC_HISTORY_EN
        hist_idx  = '0;
`endif
        test_reset();
        test_normal_halt();
        test_restart();
        test_timeout();
        test_simultaneous();
        test_reset_midrun();
`ifdef RUN_MON_PC_HISTORY_EN
        test_history();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

`default_nettype wire
